// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: index geometry, entry layout,
// and the circular index increment that skips reserved index 0.
package rob_pkg;

  localparam int ROB_IW    = 4;
  localparam int ROB_DW    = 32;
  localparam int ROB_RW    = 5;
  localparam int ROB_DEPTH = (1 << ROB_IW) - 1;
  localparam logic [ROB_IW-1:0] ROB_NONE = '0;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              wr;
    logic [ROB_RW-1:0] rd;
    logic [ROB_DW-1:0] data;
  } rob_entry_t;

  // Index 0 means "no producer", so the ring runs 1..ROB_DEPTH.
  function automatic logic [ROB_IW-1:0] rob_next(input logic [ROB_IW-1:0] idx);
    return (idx == ROB_IW'(ROB_DEPTH)) ? ROB_IW'(1) : idx + ROB_IW'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / rename-tag / CDB / commit bundle of the reorder buffer.
// Optional operand-read ports are present only when ROB_OPERAND_READ_EN is defined.
interface reorder_buffer_if #(
  parameter int DW = 32,
  parameter int IW = 4
);
  logic          disp_a_valid, disp_b_valid;
  logic          disp_a_wr, disp_b_wr;
  logic [4:0]    disp_a_rd, disp_b_rd;
  logic          disp_ready;
  logic [IW-1:0] disp_a_index, disp_b_index;

  logic          wlwta, wlwtb;
  logic [4:0]    wlwt_wna, wlwt_wnb;
  logic [IW-1:0] wlwt_ROB_index_a, wlwt_ROB_index_b;

  logic          cdb_a_valid, cdb_b_valid;
  logic [IW-1:0] cdb_a_index, cdb_b_index;
  logic [DW-1:0] cdb_a_data, cdb_b_data;

  logic          wea, web;
  logic [4:0]    wna, wnb;
  logic [DW-1:0] dataina, datainb;
  logic [IW-1:0] ROB_index_wta, ROB_index_wtb;

  logic [IW-1:0] count;
  logic          empty;

`ifdef ROB_OPERAND_READ_EN
  logic [IW-1:0] rd_idx_a, rd_idx_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_ready_a, rd_ready_b;
`endif

  modport slave (
    input  disp_a_valid, disp_b_valid, disp_a_wr, disp_b_wr, disp_a_rd, disp_b_rd,
    output disp_ready, disp_a_index, disp_b_index,
    output wlwta, wlwtb, wlwt_wna, wlwt_wnb, wlwt_ROB_index_a, wlwt_ROB_index_b,
    input  cdb_a_valid, cdb_b_valid, cdb_a_index, cdb_b_index, cdb_a_data, cdb_b_data,
    output wea, web, wna, wnb, dataina, datainb, ROB_index_wta, ROB_index_wtb,
    output count, empty
`ifdef ROB_OPERAND_READ_EN
    , input  rd_idx_a, rd_idx_b
    , output rd_data_a, rd_data_b, rd_ready_a, rd_ready_b
`endif
  );

  modport master (
    output disp_a_valid, disp_b_valid, disp_a_wr, disp_b_wr, disp_a_rd, disp_b_rd,
    input  disp_ready, disp_a_index, disp_b_index,
    input  wlwta, wlwtb, wlwt_wna, wlwt_wnb, wlwt_ROB_index_a, wlwt_ROB_index_b,
    output cdb_a_valid, cdb_b_valid, cdb_a_index, cdb_b_index, cdb_a_data, cdb_b_data,
    input  wea, web, wna, wnb, dataina, datainb, ROB_index_wta, ROB_index_wtb,
    input  count, empty
`ifdef ROB_OPERAND_READ_EN
    , output rd_idx_a, rd_idx_b
    , input  rd_data_a, rd_data_b, rd_ready_a, rd_ready_b
`endif
  );

endinterface

// File: rtl/rob_commit_select.sv
// Inspects the head entry and its successor and produces the in-order commit
// slot fires plus the register-file write port values.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic [IW-1:0] head,
  input  logic [IW-1:0] head_n,
  input  rob_entry_t    ent_a,
  input  rob_entry_t    ent_b,
  output logic          fire_a,
  output logic          fire_b,
  output logic          we_a,
  output logic          we_b,
  output logic [4:0]    wn_a,
  output logic [4:0]    wn_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic [IW-1:0] idx_a,
  output logic [IW-1:0] idx_b
);

  always_comb begin
    fire_a = ent_a.valid & ent_a.done;
    // The younger slot may only retire alongside the older one.
    fire_b = fire_a & ent_b.valid & ent_b.done;

    we_a   = fire_a & ent_a.wr & (ent_a.rd != '0);
    we_b   = fire_b & ent_b.wr & (ent_b.rd != '0);

    wn_a   = fire_a ? ent_a.rd : '0;
    wn_b   = fire_b ? ent_b.rd : '0;
    data_a = fire_a ? DW'(ent_a.data) : '0;
    data_b = fire_b ? DW'(ent_b.data) : '0;
    idx_a  = fire_a ? head : '0;
    idx_b  = fire_b ? head_n : '0;
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: dual dispatch with rename-tag outputs, two CDB ports,
// dual in-order retire. Optional operand read ports under ROB_OPERAND_READ_EN.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DW = ROB_DW,
  parameter int IW = ROB_IW
) (
  input logic              clk,
  input logic              rst,
  reorder_buffer_if.slave  bus
);

  rob_entry_t    ent [2**IW];
  logic [IW-1:0] head, tail, count;
  logic [IW-1:0] head_n, tail_n;
  logic          ready, acc_a, acc_b;
  logic          fire_a, fire_b;
  logic          hit_a, hit_b;

  assign head_n = rob_next(head);
  assign tail_n = rob_next(tail);

  // Pre-retire count gates dispatch, so slots freed this cycle are not reused.
  assign ready = (count < IW'(ROB_DEPTH - 1));
  assign acc_a = bus.disp_a_valid & ready;
  assign acc_b = acc_a & bus.disp_b_valid;

  assign hit_a = bus.cdb_a_valid & (bus.cdb_a_index != IW'(ROB_NONE))
               & ent[bus.cdb_a_index].valid & ~ent[bus.cdb_a_index].done;
  assign hit_b = bus.cdb_b_valid & (bus.cdb_b_index != IW'(ROB_NONE))
               & ent[bus.cdb_b_index].valid & ~ent[bus.cdb_b_index].done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= IW'(1);
      tail  <= IW'(1);
      count <= '0;
      for (int unsigned i = 0; i < 2**IW; i++) ent[i] <= '0;
    end else begin
      if (fire_a) begin
        ent[head].valid <= 1'b0;
        ent[head].done  <= 1'b0;
      end
      if (fire_b) begin
        ent[head_n].valid <= 1'b0;
        ent[head_n].done  <= 1'b0;
      end
      if (acc_a) begin
        ent[tail].valid <= 1'b1;
        ent[tail].done  <= 1'b0;
        ent[tail].wr    <= bus.disp_a_wr;
        ent[tail].rd    <= bus.disp_a_rd;
        ent[tail].data  <= '0;
      end
      if (acc_b) begin
        ent[tail_n].valid <= 1'b1;
        ent[tail_n].done  <= 1'b0;
        ent[tail_n].wr    <= bus.disp_b_wr;
        ent[tail_n].rd    <= bus.disp_b_rd;
        ent[tail_n].data  <= '0;
      end
      // Port a is written last so it wins when both strobes name one index.
      if (hit_b) begin
        ent[bus.cdb_b_index].done <= 1'b1;
        ent[bus.cdb_b_index].data <= bus.cdb_b_data;
      end
      if (hit_a) begin
        ent[bus.cdb_a_index].done <= 1'b1;
        ent[bus.cdb_a_index].data <= bus.cdb_a_data;
      end

      head  <= fire_b ? rob_next(head_n) : (fire_a ? head_n : head);
      tail  <= acc_b ? rob_next(tail_n) : (acc_a ? tail_n : tail);
      count <= count + IW'(acc_a) + IW'(acc_b) - IW'(fire_a) - IW'(fire_b);
    end
  end

  rob_commit_select #(
    .DW(DW),
    .IW(IW)
  ) u_commit (
    .head   (head),
    .head_n (head_n),
    .ent_a  (ent[head]),
    .ent_b  (ent[head_n]),
    .fire_a (fire_a),
    .fire_b (fire_b),
    .we_a   (bus.wea),
    .we_b   (bus.web),
    .wn_a   (bus.wna),
    .wn_b   (bus.wnb),
    .data_a (bus.dataina),
    .data_b (bus.datainb),
    .idx_a  (bus.ROB_index_wta),
    .idx_b  (bus.ROB_index_wtb)
  );

  assign bus.disp_ready       = ready;
  assign bus.disp_a_index     = tail;
  assign bus.disp_b_index     = tail_n;
  assign bus.wlwta            = acc_a & bus.disp_a_wr & (bus.disp_a_rd != '0);
  assign bus.wlwtb            = acc_b & bus.disp_b_wr & (bus.disp_b_rd != '0);
  assign bus.wlwt_wna         = acc_a ? bus.disp_a_rd : '0;
  assign bus.wlwt_wnb         = acc_b ? bus.disp_b_rd : '0;
  assign bus.wlwt_ROB_index_a = acc_a ? tail : '0;
  assign bus.wlwt_ROB_index_b = acc_b ? tail_n : '0;
  assign bus.count            = count;
  assign bus.empty            = (count == '0);

`ifdef ROB_OPERAND_READ_EN
  always_comb begin
    bus.rd_ready_a = 1'b0;
    bus.rd_data_a  = '0;
    if (bus.rd_idx_a != IW'(ROB_NONE)) begin
      if (hit_a && bus.cdb_a_index == bus.rd_idx_a) begin
        bus.rd_ready_a = 1'b1;
        bus.rd_data_a  = bus.cdb_a_data;
      end else if (hit_b && bus.cdb_b_index == bus.rd_idx_a) begin
        bus.rd_ready_a = 1'b1;
        bus.rd_data_a  = bus.cdb_b_data;
      end else if (ent[bus.rd_idx_a].valid && ent[bus.rd_idx_a].done) begin
        bus.rd_ready_a = 1'b1;
        bus.rd_data_a  = DW'(ent[bus.rd_idx_a].data);
      end
    end
  end

  always_comb begin
    bus.rd_ready_b = 1'b0;
    bus.rd_data_b  = '0;
    if (bus.rd_idx_b != IW'(ROB_NONE)) begin
      if (hit_a && bus.cdb_a_index == bus.rd_idx_b) begin
        bus.rd_ready_b = 1'b1;
        bus.rd_data_b  = bus.cdb_a_data;
      end else if (hit_b && bus.cdb_b_index == bus.rd_idx_b) begin
        bus.rd_ready_b = 1'b1;
        bus.rd_data_b  = bus.cdb_b_data;
      end else if (ent[bus.rd_idx_b].valid && ent[bus.rd_idx_b].done) begin
        bus.rd_ready_b = 1'b1;
        bus.rd_data_b  = DW'(ent[bus.rd_idx_b].data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: reset state, dispatch tags,
// in-order commit, out-of-order completion, full/ready, wrap-around, rd = 0.
module tb_reorder_buffer;

  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DW(DW), .IW(IW)) bus ();

  reorder_buffer #(.DW(DW), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks    = 0;
  int failures  = 0;
  int zero_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] i);
    return (i == 4'd15) ? 4'd1 : i + 4'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_disp();
    bus.disp_a_valid = 1'b0; bus.disp_b_valid = 1'b0;
    bus.disp_a_wr    = 1'b0; bus.disp_b_wr    = 1'b0;
    bus.disp_a_rd    = '0;   bus.disp_b_rd    = '0;
  endtask

  task automatic clear_cdb();
    bus.cdb_a_valid = 1'b0; bus.cdb_b_valid = 1'b0;
    bus.cdb_a_index = '0;   bus.cdb_b_index = '0;
    bus.cdb_a_data  = '0;   bus.cdb_b_data  = '0;
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (bus.empty !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, bus.empty, 1'b1);
  endtask

  always @(negedge clk)
    if (!rst && (bus.disp_a_index == '0 || bus.disp_b_index == '0)) zero_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t;
    logic [3:0] h;

    rst = 1'b1;
    clear_disp();
    clear_cdb();
    #3;
    check("rst_ready",  bus.disp_ready, 1'b1);
    check("rst_empty",  bus.empty, 1'b1);
    check("rst_count",  bus.count, 4'd0);
    check("rst_idx_a",  bus.disp_a_index, 4'd1);
    check("rst_idx_b",  bus.disp_b_index, 4'd2);
    check("rst_wea",    bus.wea, 1'b0);
    check("rst_wlwta",  bus.wlwta, 1'b0);
    check("rst_tag_a",  bus.wlwt_ROB_index_a, 4'd0);
    check("rst_idx_wt", bus.ROB_index_wta, 4'd0);
    step();
    rst = 1'b0;

    // Single dispatch, rd = 3.
    bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd3;
    #1;
    check("d1_idx_a", bus.disp_a_index, 4'd1);
    check("d1_wlwta", bus.wlwta, 1'b1);
    check("d1_wna",   bus.wlwt_wna, 5'd3);
    check("d1_tag_a", bus.wlwt_ROB_index_a, 4'd1);
    check("d1_wlwtb", bus.wlwtb, 1'b0);
    step();
    clear_disp();
    check("d1_count", bus.count, 4'd1);
    check("d1_empty", bus.empty, 1'b0);

    // Completion, then commit one cycle later.
    bus.cdb_a_valid = 1'b1; bus.cdb_a_index = 4'd1; bus.cdb_a_data = 32'hDEADBEEF;
    #1;
    check("c1_wea_early", bus.wea, 1'b0);
    step();
    clear_cdb();
    #1;
    check("c1_wea",    bus.wea, 1'b1);
    check("c1_wna",    bus.wna, 5'd3);
    check("c1_data",   bus.dataina, 32'hDEADBEEF);
    check("c1_idx",    bus.ROB_index_wta, 4'd1);
    check("c1_web",    bus.web, 1'b0);
    step();
    check("c1_count",  bus.count, 4'd0);
    check("c1_empty",  bus.empty, 1'b1);

    // Pair dispatch at 2,3 then out-of-order completion.
    bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd5;
    bus.disp_b_valid = 1'b1; bus.disp_b_wr = 1'b1; bus.disp_b_rd = 5'd6;
    #1;
    check("p_idx_a", bus.disp_a_index, 4'd2);
    check("p_idx_b", bus.disp_b_index, 4'd3);
    check("p_wlwtb", bus.wlwtb, 1'b1);
    check("p_wnb",   bus.wlwt_wnb, 5'd6);
    check("p_tag_b", bus.wlwt_ROB_index_b, 4'd3);
    step();
    clear_disp();
    check("p_count", bus.count, 4'd2);
    bus.cdb_a_valid = 1'b1; bus.cdb_a_index = 4'd3; bus.cdb_a_data = 32'h33;
    step();
    bus.cdb_a_index = 4'd2; bus.cdb_a_data = 32'h22;
    #1;
    check("ooo_wea_hold", bus.wea, 1'b0);
    check("ooo_web_hold", bus.web, 1'b0);
    check("ooo_count",    bus.count, 4'd2);
    step();
    clear_cdb();
    #1;
    check("ooo_wea",   bus.wea, 1'b1);
    check("ooo_wna",   bus.wna, 5'd5);
    check("ooo_data_a", bus.dataina, 32'h22);
    check("ooo_idx_a", bus.ROB_index_wta, 4'd2);
    check("ooo_web",   bus.web, 1'b1);
    check("ooo_wnb",   bus.wnb, 5'd6);
    check("ooo_data_b", bus.datainb, 32'h33);
    check("ooo_idx_b", bus.ROB_index_wtb, 4'd3);
    step();
    check("ooo_count_after", bus.count, 4'd0);

    // rd = 0 with wr = 1 at index 4: no tag update, silent retire.
    bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd0;
    #1;
    check("r0_idx_a", bus.disp_a_index, 4'd4);
    check("r0_wlwta", bus.wlwta, 1'b0);
    step();
    clear_disp();
    check("r0_count", bus.count, 4'd1);
    bus.cdb_a_valid = 1'b1; bus.cdb_a_index = 4'd4; bus.cdb_a_data = 32'h1;
    step();
    clear_cdb();
    #1;
    check("r0_wea",      bus.wea, 1'b0);
    check("r0_idx_wt",   bus.ROB_index_wta, 4'd4);
    step();
    check("r0_count_after", bus.count, 4'd0);

    // Both CDB ports name index 5: port a data is kept.
    bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd7;
    step();
    clear_disp();
    bus.cdb_a_valid = 1'b1; bus.cdb_a_index = 4'd5; bus.cdb_a_data = 32'hAAAA;
    bus.cdb_b_valid = 1'b1; bus.cdb_b_index = 4'd5; bus.cdb_b_data = 32'hBBBB;
    step();
    clear_cdb();
    #1;
    check("aw_wea",  bus.wea, 1'b1);
    check("aw_data", bus.dataina, 32'hAAAA);
    step();
    check("aw_count", bus.count, 4'd0);

    // Fill with 7 pairs from index 6 (wraps 15 -> 1).
    t = 4'd6;
    for (int k = 0; k < 7; k++) begin
      bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd9;
      bus.disp_b_valid = 1'b1; bus.disp_b_wr = 1'b1; bus.disp_b_rd = 5'd9;
      #1;
      check("fill_idx_a", bus.disp_a_index, t);
      check("fill_idx_b", bus.disp_b_index, nxt(t));
      step();
      t = nxt(nxt(t));
    end
    clear_disp();
    #1;
    check("full_count", bus.count, 4'd14);
    check("full_ready", bus.disp_ready, 1'b0);
    bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd9;
    #1;
    check("full_wlwta", bus.wlwta, 1'b0);
    step();
    clear_disp();
    check("full_count_hold", bus.count, 4'd14);
    bus.cdb_a_valid = 1'b1; bus.cdb_a_index = 4'd6; bus.cdb_a_data = 32'h66;
    step();
    clear_cdb();
    #1;
    check("full_wea",   bus.wea, 1'b1);
    check("full_idx",   bus.ROB_index_wta, 4'd6);
    check("full_data",  bus.dataina, 32'h66);
    check("full_web",   bus.web, 1'b0);
    check("full_ready_pre", bus.disp_ready, 1'b0);
    step();
    check("full_count_13", bus.count, 4'd13);
    check("full_ready_post", bus.disp_ready, 1'b1);

    // Drain the 13 remaining entries: 7..15, 1..4.
    h = 4'd7;
    for (int j = 0; j < 13; j += 2) begin
      bus.cdb_a_valid = 1'b1; bus.cdb_a_index = h; bus.cdb_a_data = 32'(h);
      h = nxt(h);
      if (j + 1 < 13) begin
        bus.cdb_b_valid = 1'b1; bus.cdb_b_index = h; bus.cdb_b_data = 32'(h);
        h = nxt(h);
      end else begin
        bus.cdb_b_valid = 1'b0;
      end
      step();
    end
    clear_cdb();
    wait_empty("drain_empty", 20);
    check("drain_tail", bus.disp_a_index, 4'd5);

    // Three more fill/drain rounds of 10 entries each; 30 steps returns tail to 5.
    for (int r = 0; r < 3; r++) begin
      h = t;
      for (int k = 0; k < 5; k++) begin
        bus.disp_a_valid = 1'b1; bus.disp_a_wr = 1'b1; bus.disp_a_rd = 5'd12;
        bus.disp_b_valid = 1'b1; bus.disp_b_wr = 1'b0; bus.disp_b_rd = 5'd13;
        #1;
        check("wrap_idx_a", bus.disp_a_index, t);
        step();
        t = nxt(nxt(t));
      end
      clear_disp();
      for (int k = 0; k < 5; k++) begin
        bus.cdb_a_valid = 1'b1; bus.cdb_a_index = h;      bus.cdb_a_data = 32'h100;
        bus.cdb_b_valid = 1'b1; bus.cdb_b_index = nxt(h); bus.cdb_b_data = 32'h200;
        h = nxt(nxt(h));
        step();
      end
      clear_cdb();
      wait_empty("wrap_empty", 20);
    end
    check("wrap_tail",   bus.disp_a_index, 4'd5);
    check("wrap_count",  bus.count, 4'd0);
    check("no_zero_idx", zero_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer sitting directly upstream of the integer register file. Allocates 4-bit ROB indices at dual dispatch and drives the register file's rename-tag ports (wlwt*). Collects results from two completion (CDB) ports and retires up to two entries per cycle in program order, driving the register file's tagged write ports (wea/web). Index 0 is reserved as "no producer", so usable indices are 1..15.

## Interface
Parameters:
- DW, 32, data width
- IW, 4, index width; depth = 2^IW − 1 = 15 entries, indices 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- disp_a_valid, disp_b_valid  in  1  dispatch requests; b honoured only together with a
- disp_a_wr, disp_b_wr  in  1  instruction writes a register
- disp_a_rd, disp_b_rd  in  5  destination register
- disp_ready  out  1  ≥2 free entries
- disp_a_index, disp_b_index  out  IW  indices allocated this cycle
- wlwta, wlwtb  out  1  rename-tag update enables
- wlwt_wna, wlwt_wnb  out  5  rename-tag register numbers
- wlwt_ROB_index_a, wlwt_ROB_index_b  out  IW  rename tags
- cdb_a_valid, cdb_b_valid  in  1  completion strobes
- cdb_a_index, cdb_b_index  in  IW  completing entry
- cdb_a_data, cdb_b_data  in  DW  result
- wea, web  out  1  commit write enables (a = older)
- wna, wnb  out  5  commit register numbers
- dataina, datainb  out  DW  commit data
- ROB_index_wta, ROB_index_wtb  out  IW  committing indices
- count  out  IW  occupied entries, 0..15
- empty  out  1  count == 0

## Operation
- Entry fields: valid, done, wr, rd, data. head and tail pointers in 1..15; increment wraps 15 → 1.
- Dispatch accepted when disp_a_valid & disp_ready. a takes tail, b takes next(tail). Tail advances by 1 or 2.
- disp_a_index = tail and disp_b_index = next(tail) at all times, combinational.
- wlwta = accepted a & disp_a_wr & (disp_a_rd != 0); wlwt_wna = disp_a_rd; wlwt_ROB_index_a = disp_a_index. b is analogous.
- A CDB strobe to a valid, not-done entry sets done and stores data. Strobes to index 0 or to an invalid entry are ignored. If a and b name the same index, a wins.
- Commit slot a fires when entry[head] is valid and done. Slot b fires when slot a fires and entry[next(head)] is valid and done.
- wea = slot a fires & wr & (rd != 0). Entries with wr = 0 retire silently. web is analogous for slot b.
- count' = count + accepted − retired. empty = (count == 0).

## Timing
- Reset: head = tail = 1, count = 0, all valid/done cleared. All outputs 0 except: disp_ready = 1, empty = 1, disp_a_index = 1, disp_b_index = 2.
- Dispatch outputs, including wlwt*, are combinational in the request cycle. The register file captures them on the same edge.
- CDB strobe at edge N → entry done after N. Commit outputs are combinational from entry state and are asserted in cycle N+1. The register file writes and the entry retires at edge N+1.
- Minimum dispatch-to-retire latency is 2 edges.
- Dispatch, CDB and commit in the same cycle all take effect. Freed entries are not reusable until the following cycle: disp_ready uses the pre-retire count.
- Full: count ≥ 14 → disp_ready = 0, so a pair is never split.
- rst asserted mid-operation immediately clears all entries; in-flight results are discarded.

## Configuration
- ROB_OPERAND_READ_EN defined:
  - Adds inputs rd_idx_a and rd_idx_b (IW).
  - Adds outputs rd_data_a and rd_data_b (DW), and rd_ready_a and rd_ready_b (1).
  - ready = entry valid & done, or a same-cycle CDB strobe to that index; data bypassed from the CDB in the strobe case.
  - Index 0 → ready 0, data 0.
- Undefined: these ports and their logic are absent.

## Structure
- Package rob_pkg holds:
  - ROB_IW, ROB_DEPTH, ROB_NONE = 0
  - typedef rob_entry_t {valid, done, wr, rd, data}
  - function rob_next(idx): wraps 15 → 1
- One sub-module, rob_commit_select: combinational head/head+1 inspection producing the slot fire signals and the commit port values.

## Test plan
- Reset then dispatch a (rd = 3, wr) → disp_a_index = 1, wlwta = 1, wlwt_wna = 3, wlwt_ROB_index_a = 1.
- CDB a index 1, data 0xDEADBEEF → next cycle wea = 1, wna = 3, dataina = 0xDEADBEEF, ROB_index_wta = 1; after the edge count = 0.
- Dispatch pairs until count = 14 → disp_ready = 0. Complete index 1 → one retires, count = 13, disp_ready = 1 the following cycle.
- Out-of-order completion, index 2 before index 1 → nothing commits. When index 1 completes, both commit in the same cycle, with wea/web in order.
- Fill and drain repeatedly past 15 → index wraps 15 → 1, and index 0 is never allocated.
- Dispatch rd = 0, wr = 1 → wlwta = 0; on retire wea = 0, and count still decrements.
